pacman_video_timing: RTL and testbench

Upstream video timing and coordinate generator for `pacman_game`. Divides the system clock into a 640x480@60 VGA pixel strobe and runs the horizontal and vertical raster counters. It produces the VGA sync signals and display-enable, and maps the raster into the centred 224x288 game window. Its outputs are the `sx`/`sy`, `game_pix_stb`, `frame_stb` and `display_enabled` inputs that the game renderer consumes.

---
 rtl/pacman_video_timing_if.sv | 21 ++
 rtl/pacman_video_timing.sv | 133 +++++++++++++
 tb/tb_pacman_video_timing.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pacman_video_timing_if.sv
// Raster timing bundle from pacman_video_timing to the game renderer.
interface pacman_video_timing_if #(
    parameter int unsigned SX_W = 8,
    parameter int unsigned SY_W = 9
);
    logic            vga_pix_stb;
    logic            hsync;
    logic            vsync;
    logic            display_enabled;
    logic            game_pix_stb;
    logic            frame_stb;
    logic [SX_W-1:0] sx;
    logic [SY_W-1:0] sy;

    modport master (
        output vga_pix_stb, hsync, vsync, display_enabled, game_pix_stb, frame_stb, sx, sy
    );
    modport slave (
        input vga_pix_stb, hsync, vsync, display_enabled, game_pix_stb, frame_stb, sx, sy
    );
endinterface

// File: rtl/pacman_video_timing.sv
// VGA raster counters, sync decode and centred game-window coordinates for pacman_game.
// Define PACMAN_VIDEO_SYNC_ALIGN_EN to delay hsync/vsync/display_enabled by 2 pixels.
module pacman_video_timing #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned GAME_W   = 224,
    parameter int unsigned GAME_H   = 288,
    parameter int unsigned H_OFF    = 208,
    parameter int unsigned V_OFF    = 96,
    parameter bit          SYNC_NEG = 1'b1
) (
    input logic                   clk,
    input logic                   rst,
    pacman_video_timing_if.master vid
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned SXW     = $clog2(GAME_W);
    localparam int unsigned SYW     = $clog2(GAME_H);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] HWIN_BEG = HW'(H_OFF);
    localparam logic [HW-1:0] HWIN_END = HW'(H_OFF + GAME_W);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] VWIN_BEG = VW'(V_OFF);
    localparam logic [VW-1:0] VWIN_END = VW'(V_OFF + GAME_H);
    localparam logic          SYNC_IDLE = SYNC_NEG;
    localparam logic          SYNC_ACT  = ~SYNC_NEG;

    initial begin
        if (H_OFF + GAME_W > H_ACTIVE) $error("game window exceeds horizontal active area");
        if (V_OFF + GAME_H > V_ACTIVE) $error("game window exceeds vertical active area");
    end

    logic [DW-1:0]  div_q;
    logic [HW-1:0]  hcnt_q;
    logic [VW-1:0]  vcnt_q;
    logic           tick, h_last, v_last, de_dec, hs_dec, vs_dec, in_win;
    logic           pix_q, gp_q, fs_q, hs_q, vs_q, de_q;
    logic [SXW-1:0] sx_q;
    logic [SYW-1:0] sy_q;

    always_comb begin
        tick   = (div_q == DIV_LAST);
        h_last = (hcnt_q == H_LAST);
        v_last = (vcnt_q == V_LAST);
        de_dec = (hcnt_q < H_ACT_C) && (vcnt_q < V_ACT_C);
        hs_dec = (hcnt_q >= HS_BEG) && (hcnt_q < HS_END);
        vs_dec = (vcnt_q >= VS_BEG) && (vcnt_q < VS_END);
        in_win = (hcnt_q >= HWIN_BEG) && (hcnt_q < HWIN_END) &&
                 (vcnt_q >= VWIN_BEG) && (vcnt_q < VWIN_END);
    end

    // Level outputs only move on tick; strobes are rewritten every clk so they stay 1 clk wide.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q  <= '0;
            hcnt_q <= '0;
            vcnt_q <= '0;
            pix_q  <= 1'b0;
            gp_q   <= 1'b0;
            fs_q   <= 1'b0;
            hs_q   <= SYNC_IDLE;
            vs_q   <= SYNC_IDLE;
            de_q   <= 1'b0;
            sx_q   <= '0;
            sy_q   <= '0;
        end else begin
            div_q <= tick ? '0 : div_q + 1'b1;
            pix_q <= tick;
            gp_q  <= tick && in_win;
            fs_q  <= tick && (hcnt_q == '0) && (vcnt_q == '0);
            if (tick) begin
                hcnt_q <= h_last ? '0 : hcnt_q + 1'b1;
                if (h_last) begin
                    vcnt_q <= v_last ? '0 : vcnt_q + 1'b1;
                end
                hs_q <= hs_dec ? SYNC_ACT : SYNC_IDLE;
                vs_q <= vs_dec ? SYNC_ACT : SYNC_IDLE;
                de_q <= de_dec;
                sx_q <= in_win ? SXW'(hcnt_q - HWIN_BEG) : '0;
                sy_q <= in_win ? SYW'(vcnt_q - VWIN_BEG) : '0;
            end
        end
    end

`ifdef PACMAN_VIDEO_SYNC_ALIGN_EN
    logic [1:0] hs_dly_q, vs_dly_q, de_dly_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_dly_q <= {2{SYNC_IDLE}};
            vs_dly_q <= {2{SYNC_IDLE}};
            de_dly_q <= 2'b00;
        end else if (tick) begin
            hs_dly_q <= {hs_dly_q[0], hs_q};
            vs_dly_q <= {vs_dly_q[0], vs_q};
            de_dly_q <= {de_dly_q[0], de_q};
        end
    end

    assign vid.hsync           = hs_dly_q[1];
    assign vid.vsync           = vs_dly_q[1];
    assign vid.display_enabled = de_dly_q[1];
`else
    assign vid.hsync           = hs_q;
    assign vid.vsync           = vs_q;
    assign vid.display_enabled = de_q;
`endif

    assign vid.vga_pix_stb  = pix_q;
    assign vid.game_pix_stb = gp_q;
    assign vid.frame_stb    = fs_q;
    assign vid.sx           = sx_q;
    assign vid.sy           = sy_q;
endmodule

// File: tb/tb_pacman_video_timing.sv
// Bench for pacman_video_timing on a scaled-down raster (28x17 pixels) with CLK_DIV 4 and 1,
// checked every clk against an arithmetic raster model plus fixed vectors and corner sequences.
module tb_pacman_video_timing;
    localparam int D   = 4;
    localparam int HA  = 20;
    localparam int HFP = 2;
    localparam int HS  = 3;
    localparam int HBP = 3;
    localparam int VA  = 12;
    localparam int VFP = 1;
    localparam int VS  = 2;
    localparam int VBP = 2;
    localparam int GW  = 8;
    localparam int GH  = 6;
    localparam int HO  = 6;
    localparam int VO  = 3;
    localparam int HT  = HA + HFP + HS + HBP;
    localparam int VT  = VA + VFP + VS + VBP;
`ifdef PACMAN_VIDEO_SYNC_ALIGN_EN
    localparam int ALIGN_DLY = 2;
`else
    localparam int ALIGN_DLY = 0;
`endif

    typedef struct packed {
        logic       pix;
        logic       hs;
        logic       vs;
        logic       de;
        logic       gp;
        logic       fs;
        logic [2:0] sx;
        logic [2:0] sy;
    } vout_t;

    typedef struct {
        logic  r;
        int    n;
        vout_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   c4 = 0;
    int   c1 = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    pacman_video_timing_if #(.SX_W(3), .SY_W(3)) vid4 ();
    pacman_video_timing_if #(.SX_W(3), .SY_W(3)) vid1 ();

    pacman_video_timing #(
        .CLK_DIV(D), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .GAME_W(GW), .GAME_H(GH), .H_OFF(HO), .V_OFF(VO), .SYNC_NEG(1'b1)
    ) dut4 (.clk(clk), .rst(rst), .vid(vid4));

    pacman_video_timing #(
        .CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .GAME_W(GW), .GAME_H(GH), .H_OFF(HO), .V_OFF(VO), .SYNC_NEG(1'b1)
    ) dut1 (.clk(clk), .rst(rst), .vid(vid1));

    function automatic vout_t vo(input logic pix, input logic hs, input logic vs, input logic de,
                                 input logic gp, input logic fs, input int sx, input int sy);
        vout_t e;
        e.pix = pix; e.hs = hs; e.vs = vs; e.de = de; e.gp = gp; e.fs = fs;
        e.sx = 3'(sx); e.sy = 3'(sy);
        return e;
    endfunction

    // c = clocks since reset release; pixel p is the counter position sampled at the latest tick.
    function automatic vout_t model(input int c, input int d);
        vout_t e;
        int p, h, v, q, qh, qv;
        bit win;
        e = vo(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        if (c < d) return e;
        p = c / d - 1;
        h = p % HT;
        v = (p / HT) % VT;
        win = (h >= HO) && (h < HO + GW) && (v >= VO) && (v < VO + GH);
        if (c % d == 0) begin
            e.pix = 1'b1;
            e.gp  = win;
            e.fs  = (h == 0) && (v == 0);
        end
        if (win) begin
            e.sx = 3'(h - HO);
            e.sy = 3'(v - VO);
        end
        q = p - ALIGN_DLY;
        if (q >= 0) begin
            qh = q % HT;
            qv = (q / HT) % VT;
            e.hs = !((qh >= HA + HFP) && (qh < HA + HFP + HS));
            e.vs = !((qv >= VA + VFP) && (qv < VA + VFP + VS));
            e.de = (qh < HA) && (qv < VA);
        end
        return e;
    endfunction

    function automatic vout_t grab4();
        return vo(vid4.vga_pix_stb, vid4.hsync, vid4.vsync, vid4.display_enabled,
                  vid4.game_pix_stb, vid4.frame_stb, int'(vid4.sx), int'(vid4.sy));
    endfunction

    function automatic vout_t grab1();
        return vo(vid1.vga_pix_stb, vid1.hsync, vid1.vsync, vid1.display_enabled,
                  vid1.game_pix_stb, vid1.frame_stb, int'(vid1.sx), int'(vid1.sy));
    endfunction

    task automatic check_out(input string name, input vout_t got, input vout_t exp, input int c);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s c=%0d got=%h expected=%h (pix,hs,vs,de,gp,fs,sx,sy)",
                     name, c, got, exp);
        end
    endtask

    task automatic check_eq(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic step(input logic r);
        rst = r;
        @(posedge clk);
        c4 = r ? 0 : c4 + 1;
        c1 = r ? 0 : c1 + 1;
        @(negedge clk);
        check_out("model_div4", grab4(), model(c4, D), c4);
        check_out("model_div1", grab1(), model(c1, 1), c1);
    endtask

    task automatic do_reset();
        step(1'b1);
        step(1'b1);
    endtask

    vec_t tbl[17];
    int   start, low, nxt, de_px, gp_n, fs_n, vs_low, vs_start, first_xy, last_xy, t, n, rlen;

    initial begin
        tbl[0]  = '{1'b1, 10,  vo(0, 1, 1, 0, 0, 0, 0, 0)};
        tbl[1]  = '{1'b0, 3,   vo(0, 1, 1, 0, 0, 0, 0, 0)};
        tbl[2]  = '{1'b0, 1,   vo(1, 1, 1, 1, 0, 1, 0, 0)};
        tbl[3]  = '{1'b0, 1,   vo(0, 1, 1, 1, 0, 0, 0, 0)};
        tbl[4]  = '{1'b0, 359, vo(1, 1, 1, 1, 1, 0, 0, 0)};
        tbl[5]  = '{1'b0, 1,   vo(0, 1, 1, 1, 0, 0, 0, 0)};
        tbl[6]  = '{1'b0, 27,  vo(1, 1, 1, 1, 1, 0, 7, 0)};
        tbl[7]  = '{1'b0, 4,   vo(1, 1, 1, 1, 0, 0, 0, 0)};
        tbl[8]  = '{1'b0, 32,  vo(1, 0, 1, 0, 0, 0, 0, 0)};
        tbl[9]  = '{1'b0, 524, vo(1, 1, 1, 1, 1, 0, 7, 5)};
        tbl[10] = '{1'b0, 508, vo(1, 1, 0, 0, 0, 0, 0, 0)};
        tbl[11] = '{1'b0, 444, vo(1, 1, 1, 0, 0, 0, 0, 0)};
        tbl[12] = '{1'b0, 4,   vo(1, 1, 1, 1, 0, 1, 0, 0)};
        tbl[13] = '{1'b0, 1100, vo(1, 0, 1, 0, 0, 0, 0, 0)};
        tbl[14] = '{1'b1, 1,   vo(0, 1, 1, 0, 0, 0, 0, 0)};
        tbl[15] = '{1'b0, 3,   vo(0, 1, 1, 0, 0, 0, 0, 0)};
        tbl[16] = '{1'b0, 1,   vo(1, 1, 1, 1, 0, 1, 0, 0)};

`ifndef PACMAN_VIDEO_SYNC_ALIGN_EN
        for (int i = 0; i < 17; i++) begin
            for (int k = 0; k < tbl[i].n; k++) step(tbl[i].r);
            check_out($sformatf("table[%0d]", i), grab4(), tbl[i].exp, c4);
        end
`endif

        // Line timing: hsync position, width, line length and active pixels per line.
        do_reset();
        start = -1;
        for (int i = 0; i < 2 * HT * D && start < 0; i++) begin
            step(1'b0);
            if (vid4.hsync == 1'b0) start = c4;
        end
        check_eq("hsync_start_clk", start, (HA + HFP + ALIGN_DLY + 1) * D);
        low = 1;
        for (int i = 0; i < HT * D; i++) begin
            step(1'b0);
            if (vid4.hsync == 1'b0) low++;
            else break;
        end
        check_eq("hsync_low_clk", low, HS * D);
        de_px = 0;
        nxt = -1;
        for (int i = 0; i < 2 * HT * D && nxt < 0; i++) begin
            step(1'b0);
            if (vid4.vga_pix_stb && vid4.display_enabled) de_px++;
            if (vid4.hsync == 1'b0) nxt = c4;
        end
        check_eq("line_len_clk", nxt - start, HT * D);
        check_eq("de_pixels_per_line", de_px, HA);

        // One full frame: game window coverage, vsync placement, frame strobe period.
        do_reset();
        gp_n = 0; fs_n = 0; vs_low = 0; vs_start = -1; first_xy = -1; last_xy = -1;
        for (int i = 0; i < HT * VT * D; i++) begin
            step(1'b0);
            if (vid4.game_pix_stb) begin
                gp_n++;
                if (first_xy < 0) first_xy = int'(vid4.sx) * 100 + int'(vid4.sy);
                last_xy = int'(vid4.sx) * 100 + int'(vid4.sy);
            end
            if (vid4.frame_stb) fs_n++;
            if (vid4.vsync == 1'b0) begin
                vs_low++;
                if (vs_start < 0) vs_start = c4;
            end
        end
        check_eq("game_pix_count", gp_n, GW * GH);
        check_eq("first_game_xy", first_xy, 0);
        check_eq("last_game_xy", last_xy, (GW - 1) * 100 + (GH - 1));
        check_eq("frame_stb_per_frame", fs_n, 1);
        check_eq("vsync_low_clk", vs_low, VS * HT * D);
        check_eq("vsync_start_clk", vs_start, ((VA + VFP) * HT + ALIGN_DLY + 1) * D);
        t = -1;
        for (int i = 0; i < 2 * HT * D && t < 0; i++) begin
            step(1'b0);
            if (vid4.frame_stb) t = c4;
        end
        check_eq("frame_period_clk", t - D, HT * VT * D);

        // CLK_DIV=1: pixel strobe never drops after reset.
        do_reset();
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0);
            if (vid1.vga_pix_stb) n++;
        end
        check_eq("div1_continuous_stb", n, 20);

        // Random reset bursts over several frames.
        rlen = 0;
        for (int i = 0; i < 8000; i++) begin
            if (rlen == 0 && $urandom_range(0, 1499) == 0) rlen = $urandom_range(1, 4);
            step(rlen > 0);
            if (rlen > 0) rlen--;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
